// File: rtl/qif_syn_current_drv_if.sv
`default_nettype none
// ============================================================================
// Module      : qif_syn_current_drv_if
// Description : Spike-event handshake bundle (valid/ready plus signed weight)
//               between a spike source and the synaptic current driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface qif_syn_current_drv_if;
    logic              spk_valid;
    logic signed [7:0] spk_weight;
    logic              spk_ready;

    modport master (output spk_valid, output spk_weight, input spk_ready);
    modport slave  (input spk_valid, input spk_weight, output spk_ready);
endinterface
`default_nettype wire

// File: rtl/qif_syn_current_drv.sv
`default_nettype none
// ============================================================================
// Module      : qif_syn_current_drv
// Description : Synaptic current driver for the 8-bit QIF neuron. Buffers
//               weighted spike events in a small FIFO, integrates them into a
//               12-bit leaky accumulator and presents it saturated to signed
//               8 bits as I_syn.
// Revision    : 1.0 - initial release
// ============================================================================
module qif_syn_current_drv #(
    parameter int DEPTH        = 4,
    parameter int DECAY_SHIFT  = 3,
    parameter int DECAY_PERIOD = 4
) (
    input  wire                         clk,
    input  wire                         rst_n,
    qif_syn_current_drv_if.slave        spk,
    input  wire                         pause,
    output logic signed [7:0]           I_syn,
    output logic                        ovf,
    output logic [$clog2(DEPTH):0]      fifo_cnt
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_DCNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(DEPTH);
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DECAY_PERIOD - 1);

    // Rounding bias that turns an arithmetic shift into truncation toward zero
    localparam logic signed [13:0] c_BIAS   = 14'((1 << DECAY_SHIFT) - 1);
    localparam logic signed [13:0] c_SUM_HI = 14'sd2047;
    localparam logic signed [13:0] c_SUM_LO = -14'sd2048;
    localparam logic signed [11:0] c_ACC_HI = 12'sh7FF;
    localparam logic signed [11:0] c_ACC_LO = 12'sh800;
    localparam logic signed [11:0] c_OUT_HI = 12'sd127;
    localparam logic signed [11:0] c_OUT_LO = -12'sd128;

    logic signed [7:0]    mem_q [DEPTH];
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic [c_DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic signed [11:0]   acc_q, acc_d;
    logic signed [7:0]    isyn_q, isyn_d;
    logic                 ovf_q, ovf_d;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_tick;
    logic signed [7:0]    w_head;
    logic signed [13:0]   w_acc_ext;
    logic signed [13:0]   w_bias_sum;
    logic signed [13:0]   w_decay;
    logic signed [13:0]   w_wext;
    logic signed [13:0]   w_sum;
    logic                 w_clamp;

    // Handshake, pop and decay-tick qualifiers
    always_comb begin
        w_push = spk.spk_valid & ready_q;
        w_pop  = (cnt_q != '0) & ~pause;
        w_tick = (dcnt_q == c_DCNT_LAST);
        w_head = mem_q[rd_ptr_q];
    end

    // FIFO pointers, occupancy, registered ready and decay counter
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + c_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - c_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        // Ready looks only at next occupancy, so a full FIFO refuses a push
        // even in a cycle where it also pops.
        ready_d = (cnt_d != c_FULL);
        dcnt_d  = w_tick ? '0 : dcnt_q + c_DCNT_W'(1);
    end

    // Leaky accumulator update with 12-bit and 8-bit saturation
    always_comb begin
        w_acc_ext  = {{2{acc_q[11]}}, acc_q};
        w_bias_sum = w_acc_ext + (acc_q[11] ? c_BIAS : 14'sd0);
        w_decay    = w_tick ? (w_bias_sum >>> DECAY_SHIFT) : 14'sd0;
        w_wext     = w_pop ? {{6{w_head[7]}}, w_head} : 14'sd0;
        w_sum      = w_acc_ext - w_decay + w_wext;

        if (w_sum > c_SUM_HI) begin
            acc_d = c_ACC_HI;
        end else if (w_sum < c_SUM_LO) begin
            acc_d = c_ACC_LO;
        end else begin
            acc_d = w_sum[11:0];
        end

        w_clamp = 1'b0;
        if (acc_d > c_OUT_HI) begin
            isyn_d  = 8'sd127;
            w_clamp = 1'b1;
        end else if (acc_d < c_OUT_LO) begin
            isyn_d  = 8'sh80;
            w_clamp = 1'b1;
        end else begin
            isyn_d  = acc_d[7:0];
        end
        ovf_d = ovf_q | w_clamp;
    end

    // Event storage; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (w_push && !rst_n) begin
            mem_q[wr_ptr_q] <= spk.spk_weight;
        end
    end

    // State registers; reset overrides any push, pop or decay in the same cycle
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            dcnt_q   <= '0;
            acc_q    <= '0;
            isyn_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            dcnt_q   <= dcnt_d;
            acc_q    <= acc_d;
            isyn_q   <= isyn_d;
            ovf_q    <= ovf_d;
        end
    end

    assign spk.spk_ready = ready_q;
    assign I_syn         = isyn_q;
    assign ovf           = ovf_q;
    assign fifo_cnt      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_qif_syn_current_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_qif_syn_current_drv
// Description : Directed-vector bench for qif_syn_current_drv. Stimulus posts
//               hand-computed expectations, tagged with the clock count at
//               which they must hold, into a scoreboard queue; a monitor
//               compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qif_syn_current_drv;

    logic              clk;
    logic              rst_n;
    logic              pause;
    logic signed [7:0] I_syn;
    logic              ovf;
    logic [2:0]        fifo_cnt;

    qif_syn_current_drv_if spk_if ();

    qif_syn_current_drv #(
        .DEPTH        (4),
        .DECAY_SHIFT  (3),
        .DECAY_PERIOD (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spk      (spk_if),
        .pause    (pause),
        .I_syn    (I_syn),
        .ovf      (ovf),
        .fifo_cnt (fifo_cnt)
    );

    typedef struct {
        int         tgt;
        string      nm;
        logic [7:0] isyn;
        logic       o;
        logic [2:0] cnt;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   base  = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to time-stamp expectations
    always @(posedge clk) cyc <= cyc + 1;

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_at(input int rel, input string nm, input int isyn,
                          input bit o, input int cnt, input bit rdy);
        exp_t e;
        e.tgt  = base + rel;
        e.nm   = nm;
        e.isyn = isyn[7:0];
        e.o    = o;
        e.cnt  = cnt[2:0];
        e.rdy  = rdy;
        sb.push_back(e);
    endtask

    // One reset edge aligned so decay ticks land where cycle % 4 == 3
    task automatic reset_sync();
        while (cyc % 4 != 2) @(negedge clk);
        base = cyc;
        exp_at(1, "reset_state", 0, 1'b0, 0, 1'b1);
        rst_n = 1'b1;
        pause = 1'b0;
        spk_if.spk_valid  = 1'b1;
        spk_if.spk_weight = 8'sd99;
        go(1);
        rst_n = 1'b0;
        spk_if.spk_valid = 1'b0;
        base = cyc;
    endtask

    // Scoreboard monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].tgt <= cyc) begin
                n_vec++;
                if (sb[i].tgt < cyc || I_syn !== sb[i].isyn || ovf !== sb[i].o ||
                    fifo_cnt !== sb[i].cnt || spk_if.spk_ready !== sb[i].rdy) begin
                    n_bad++;
                    $display("FAIL %s due=%0d cyc=%0d: got I_syn=%0d ovf=%0b cnt=%0d rdy=%0b, expected I_syn=%0d ovf=%0b cnt=%0d rdy=%0b",
                             sb[i].nm, sb[i].tgt, cyc, I_syn, ovf, fifo_cnt, spk_if.spk_ready,
                             $signed(sb[i].isyn), sb[i].o, sb[i].cnt, sb[i].rdy);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        // Reset held 3 clocks with an event offered: nothing may be pushed
        rst_n = 1'b1;
        pause = 1'b0;
        spk_if.spk_valid  = 1'b1;
        spk_if.spk_weight = 8'sd55;
        base = 0;
        exp_at(1, "rst_e1", 0, 1'b0, 0, 1'b1);
        exp_at(2, "rst_e2", 0, 1'b0, 0, 1'b1);
        exp_at(3, "rst_e3", 0, 1'b0, 0, 1'b1);
        go(3);
        rst_n = 1'b0;
        spk_if.spk_valid = 1'b0;
        base = cyc;

        // Single event +40 then decay 35, 31, 28
        exp_at(1,  "t2_push", 0,  1'b0, 1, 1'b1);
        exp_at(2,  "t2_pop",  40, 1'b0, 0, 1'b1);
        exp_at(3,  "t2_hold", 40, 1'b0, 0, 1'b1);
        exp_at(4,  "t2_dec1", 35, 1'b0, 0, 1'b1);
        exp_at(8,  "t2_dec2", 31, 1'b0, 0, 1'b1);
        exp_at(12, "t2_dec3", 28, 1'b0, 0, 1'b1);
        spk_if.spk_valid  = 1'b1;
        spk_if.spk_weight = 8'sd40;
        go(1);
        spk_if.spk_valid = 1'b0;
        go(12);

        // Residual +7 never decays
        reset_sync();
        exp_at(2,  "t3_p7_a", 7, 1'b0, 0, 1'b1);
        exp_at(4,  "t3_p7_b", 7, 1'b0, 0, 1'b1);
        exp_at(12, "t3_p7_c", 7, 1'b0, 0, 1'b1);
        spk_if.spk_valid  = 1'b1;
        spk_if.spk_weight = 8'sd7;
        go(1);
        spk_if.spk_valid = 1'b0;
        go(12);

        // Residual -7 never decays (symmetric truncation)
        reset_sync();
        exp_at(2,  "t3_m7_a", -7, 1'b0, 0, 1'b1);
        exp_at(4,  "t3_m7_b", -7, 1'b0, 0, 1'b1);
        exp_at(12, "t3_m7_c", -7, 1'b0, 0, 1'b1);
        spk_if.spk_valid  = 1'b1;
        spk_if.spk_weight = -8'sd7;
        go(1);
        spk_if.spk_valid = 1'b0;
        go(12);

        // Negative event -40 then -35, -31
        reset_sync();
        exp_at(2, "t3_m40",  -40, 1'b0, 0, 1'b1);
        exp_at(4, "t3_m35",  -35, 1'b0, 0, 1'b1);
        exp_at(8, "t3_m31",  -31, 1'b0, 0, 1'b1);
        spk_if.spk_valid  = 1'b1;
        spk_if.spk_weight = -8'sd40;
        go(1);
        spk_if.spk_valid = 1'b0;
        go(8);

        // Saturation: acc 100,200,275,375,475 then decays to 128, 112, 98
        reset_sync();
        exp_at(1,  "t4_e1",  0,   1'b0, 1, 1'b1);
        exp_at(2,  "t4_e2",  100, 1'b0, 1, 1'b1);
        exp_at(3,  "t4_e3",  127, 1'b1, 1, 1'b1);
        exp_at(4,  "t4_e4",  127, 1'b1, 1, 1'b1);
        exp_at(6,  "t4_e6",  127, 1'b1, 0, 1'b1);
        exp_at(44, "t4_128", 127, 1'b1, 0, 1'b1);
        exp_at(48, "t4_112", 112, 1'b1, 0, 1'b1);
        exp_at(52, "t4_98",  98,  1'b1, 0, 1'b1);
        spk_if.spk_valid  = 1'b1;
        spk_if.spk_weight = 8'sd100;
        go(5);
        spk_if.spk_valid = 1'b0;
        go(48);

        // Backpressure and FIFO order, then full-with-pop refusal
        reset_sync();
        exp_at(1,  "t5_c1",    0,  1'b0, 1, 1'b1);
        exp_at(4,  "t5_full",  0,  1'b0, 4, 1'b0);
        exp_at(6,  "t5_hold",  0,  1'b0, 4, 1'b0);
        exp_at(7,  "t5_pop10", 10, 1'b0, 3, 1'b1);
        exp_at(8,  "t5_pop20", 29, 1'b0, 2, 1'b1);
        exp_at(9,  "t5_pop30", 59, 1'b0, 1, 1'b1);
        exp_at(10, "t5_pop40", 99, 1'b0, 0, 1'b1);
        exp_at(14, "t5_full2", 87, 1'b0, 4, 1'b0);
        exp_at(15, "t5_refuse", 88, 1'b0, 3, 1'b1);
        exp_at(16, "t5_d16",   78, 1'b0, 2, 1'b1);
        exp_at(18, "t5_d18",   80, 1'b0, 0, 1'b1);
        exp_at(19, "t5_d19",   80, 1'b0, 0, 1'b1);
        pause = 1'b1;
        spk_if.spk_valid  = 1'b1;
        spk_if.spk_weight = 8'sd10;
        go(1); spk_if.spk_weight = 8'sd20;
        go(1); spk_if.spk_weight = 8'sd30;
        go(1); spk_if.spk_weight = 8'sd40;
        go(1); spk_if.spk_weight = 8'sd50;
        go(1); spk_if.spk_weight = 8'sd60;
        go(1);
        spk_if.spk_valid = 1'b0;
        pause = 1'b0;
        go(4);
        pause = 1'b1;
        spk_if.spk_valid  = 1'b1;
        spk_if.spk_weight = 8'sd1;
        go(4);
        pause = 1'b0;
        spk_if.spk_weight = 8'sd100;
        go(1);
        spk_if.spk_valid = 1'b0;
        go(5);

        // Reset mid-operation with 3 buffered events and acc=90
        reset_sync();
        exp_at(1,  "t6_c1",  0,   1'b0, 1, 1'b1);
        exp_at(2,  "t6_102", 102, 1'b0, 1, 1'b1);
        exp_at(3,  "t6_c2",  102, 1'b0, 2, 1'b1);
        exp_at(4,  "t6_90",  90,  1'b0, 3, 1'b1);
        exp_at(5,  "t6_rst", 0,   1'b0, 0, 1'b1);
        exp_at(6,  "t6_a",   0,   1'b0, 0, 1'b1);
        exp_at(9,  "t6_b",   0,   1'b0, 0, 1'b1);
        exp_at(14, "t6_c",   0,   1'b0, 0, 1'b1);
        pause = 1'b0;
        spk_if.spk_valid  = 1'b1;
        spk_if.spk_weight = 8'sd102;
        go(1); spk_if.spk_weight = 8'sd50;
        go(1); pause = 1'b1; spk_if.spk_weight = 8'sd51;
        go(1); spk_if.spk_weight = 8'sd52;
        go(1); rst_n = 1'b1; pause = 1'b0; spk_if.spk_weight = 8'sd53;
        go(1); rst_n = 1'b0; spk_if.spk_valid = 1'b0;
        go(10);

        go(2);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard: %0d expectations never compared", sb.size());
        end
        if (n_vec < 12) begin
            n_bad++;
            $display("FAIL coverage: only %0d vectors applied", n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0) begin
            $display("TEST FAILED");
        end else begin
            $display("TEST PASSED");
        end
        $finish;
    end

endmodule
`default_nettype wire
